// File: rtl/mem_load_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_load_queue_if                                                          |
// | MEM0 / dcache / WR side signals of the memory-stage load queue.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mem_load_queue_if #(
  parameter int CNT_W = 3
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [1:0]       in_off;
  logic [4:0]       in_wreg;
  logic             in_wen;
  logic [31:0]      in_alu;
  logic [31:0]      in_rf;
  logic [31:0]      in_pc;
  logic             dc_data_ok;
  logic [31:0]      dc_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [4:0]       out_wreg;
  logic [31:0]      out_wdata;
  logic [3:0]       out_wmask;
  logic             fwd_busy;
  logic [CNT_W-1:0] count;
  logic             spurious;

  modport slave (
    input  flush, in_valid, in_op, in_off, in_wreg, in_wen, in_alu, in_rf, in_pc,
           dc_data_ok, dc_rdata, out_ready,
    output in_ready, out_valid, out_pc, out_wreg, out_wdata, out_wmask,
           fwd_busy, count, spurious
  );

  modport master (
    output flush, in_valid, in_op, in_off, in_wreg, in_wen, in_alu, in_rf, in_pc,
           dc_data_ok, dc_rdata, out_ready,
    input  in_ready, out_valid, out_pc, out_wreg, out_wdata, out_wmask,
           fwd_busy, count, spurious
  );
endinterface
`default_nettype wire

// File: rtl/mem_load_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_load_queue                                                             |
// | In-order multi-entry MEM stage: tracks outstanding dcache loads, aligns    |
// | responses, retires to WR. Optional macro MEM_RESP_BYPASS_EN gives          |
// | zero-latency head fill.                                                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_load_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  mem_load_queue_if.slave q
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] c_OP_LB  = 3'd1;
  localparam logic [2:0] c_OP_LBU = 3'd2;
  localparam logic [2:0] c_OP_LH  = 3'd3;
  localparam logic [2:0] c_OP_LHU = 3'd4;
  localparam logic [2:0] c_OP_LWL = 3'd6;
  localparam logic [2:0] c_OP_LWR = 3'd7;

  logic [2:0]  op_q     [DEPTH];
  logic [1:0]  off_q    [DEPTH];
  logic [4:0]  wreg_q   [DEPTH];
  logic        wen_q    [DEPTH];
  logic [31:0] rf_q     [DEPTH];
  logic [31:0] pc_q     [DEPTH];
  logic [31:0] result_q [DEPTH];
  logic [3:0]  mask_q   [DEPTH];
  logic        done_q   [DEPTH];

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, drop_q, drop_d;
  logic             spur_q, spur_d;

  logic [CNT_W-1:0] w_pending;
  logic [PW-1:0]    w_resp;
  logic             w_has_pend, w_drop_hit, w_consume, w_fill, w_byp;
  logic             w_push, w_pop, w_out_valid, w_in_ready;
  logic [35:0]      w_aligned;

  // Returns {mask, data} for one load response.
  function automatic logic [35:0] align(input logic [2:0] op, input logic [1:0] off,
                                        input logic [31:0] rd, input logic [31:0] rf,
                                        input logic wen);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    logic [3:0]  m;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    d = rd;
    m = {4{wen}};
    case (op)
      c_OP_LB:  d = {{24{b[7]}}, b};
      c_OP_LBU: d = {24'b0, b};
      c_OP_LH:  d = {{16{h[15]}}, h};
      c_OP_LHU: d = {16'b0, h};
      c_OP_LWL: begin
        case (off)
          2'd3:    begin d = rd;                      m = 4'b1111; end
          2'd2:    begin d = {rd[23:0], rf[7:0]};     m = 4'b1110; end
          2'd1:    begin d = {rd[15:0], rf[15:0]};    m = 4'b1100; end
          default: begin d = {rd[7:0], rf[23:0]};     m = 4'b1000; end
        endcase
      end
      c_OP_LWR: begin
        case (off)
          2'd0:    begin d = rd;                      m = 4'b1111; end
          2'd1:    begin d = {8'b0, rd[31:8]};        m = 4'b0111; end
          2'd2:    begin d = {16'b0, rd[31:16]};      m = 4'b0011; end
          default: begin d = {24'b0, rd[31:24]};      m = 4'b0001; end
        endcase
      end
      default:  d = rd;
    endcase
    return {m, d};
  endfunction

  // Responses arrive in order, so the oldest undone entry is always the one being answered.
  always_comb begin
    w_pending = '0;
    w_resp    = head_q;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if ((CNT_W'(k) < count_q) && !done_q[head_q + PW'(k)]) begin
        w_pending = w_pending + CNT_W'(1);
        w_resp    = head_q + PW'(k);
      end
    end
  end

  assign w_has_pend = (w_pending != '0);
  assign w_drop_hit = q.dc_data_ok && (drop_q != '0);
  assign w_consume  = q.dc_data_ok && ((drop_q != '0) || w_has_pend);
  assign w_fill     = q.dc_data_ok && (drop_q == '0) && w_has_pend && !q.flush;
  assign w_aligned  = align(op_q[w_resp], off_q[w_resp], q.dc_rdata, rf_q[w_resp], wen_q[w_resp]);

`ifdef MEM_RESP_BYPASS_EN
  assign w_byp = w_fill && (w_resp == head_q);
`else
  assign w_byp = 1'b0;
`endif

  assign w_out_valid = ((count_q != '0) && done_q[head_q]) || w_byp;
  assign w_in_ready  = (count_q < CNT_W'(DEPTH)) && (drop_q == '0);
  assign w_pop       = w_out_valid && q.out_ready;
  assign w_push      = q.in_valid && w_in_ready && !q.flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    drop_d  = drop_q - CNT_W'(w_drop_hit);
    spur_d  = spur_q | (q.dc_data_ok && (drop_q == '0) && !w_has_pend);
    if (w_pop)  head_d = head_q + PW'(1);
    if (w_push) tail_d = tail_q + PW'(1);
    if (q.flush) begin
      head_d  = tail_q;
      count_d = '0;
      drop_d  = drop_q + w_pending - CNT_W'(w_consume);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      spur_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]     <= '0;
        off_q[i]    <= '0;
        wreg_q[i]   <= '0;
        wen_q[i]    <= 1'b0;
        rf_q[i]     <= '0;
        pc_q[i]     <= '0;
        result_q[i] <= '0;
        mask_q[i]   <= '0;
        done_q[i]   <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      spur_q  <= spur_d;
      // A bypassed head that retires this cycle never needs its slot written.
      if (w_fill && !(w_byp && w_pop)) begin
        result_q[w_resp] <= w_aligned[31:0];
        mask_q[w_resp]   <= w_aligned[35:32];
        done_q[w_resp]   <= 1'b1;
      end
      if (w_push) begin
        op_q[tail_q]     <= q.in_op;
        off_q[tail_q]    <= q.in_off;
        wreg_q[tail_q]   <= q.in_wreg;
        wen_q[tail_q]    <= q.in_wen;
        rf_q[tail_q]     <= q.in_rf;
        pc_q[tail_q]     <= q.in_pc;
        result_q[tail_q] <= q.in_alu;
        mask_q[tail_q]   <= {4{q.in_wen}};
        done_q[tail_q]   <= (q.in_op == 3'd0);
      end
    end
  end

  assign q.in_ready  = w_in_ready;
  assign q.out_valid = w_out_valid;
  assign q.out_pc    = pc_q[head_q];
  assign q.out_wreg  = wreg_q[head_q];
  assign q.out_wdata = w_byp ? w_aligned[31:0]  : result_q[head_q];
  assign q.out_wmask = w_byp ? w_aligned[35:32] : mask_q[head_q];
  assign q.fwd_busy  = w_has_pend;
  assign q.count     = count_q;
  assign q.spurious  = spur_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_load_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_load_queue                                                          |
// | Directed scenarios plus random traffic against a queue-based model.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_load_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_load_queue_if #(.CNT_W(CNT_W)) bus ();
  mem_load_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .q(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [4:0]  wreg;
    logic        wen;
    logic [31:0] rf;
    logic [31:0] pc;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        done;
  } ent_t;

  ent_t mq[$];
  int   mdrop;
  bit   mspur;

  // Reference alignment from byte arithmetic: returns {mask, data}.
  function automatic logic [35:0] ref_load(input int op, input int off, input logic [31:0] rd,
                                           input logic [31:0] rf, input logic wen);
    int b, h;
    logic [31:0] d;
    logic [3:0]  m;
    m = wen ? 4'hF : 4'h0;
    b = int'((rd >> (8 * off)) & 32'hFF);
    h = int'((off >= 2) ? (rd >> 16) : (rd & 32'hFFFF));
    d = rd;
    case (op)
      1: d = (b >= 128) ? 32'(b - 256) : 32'(b);
      2: d = 32'(b);
      3: d = (h >= 32768) ? 32'(h - 65536) : 32'(h);
      4: d = 32'(h);
      6: begin
        d = (rd << (8 * (3 - off))) | (rf & ((32'h1 << (8 * (3 - off))) - 32'h1));
        m = 4'(4'hF << (3 - off));
      end
      7: begin
        d = rd >> (8 * off);
        m = 4'hF >> off;
      end
      default: d = rd;
    endcase
    return {m, d};
  endfunction

  task automatic idle_inputs();
    bus.flush = 0; bus.in_valid = 0; bus.in_op = 0; bus.in_off = 0; bus.in_wreg = 0;
    bus.in_wen = 0; bus.in_alu = 0; bus.in_rf = 0; bus.in_pc = 0;
    bus.dc_data_ok = 0; bus.dc_rdata = 0; bus.out_ready = 0;
  endtask

  task automatic drive_enq(input logic [2:0] op, input logic [1:0] off, input logic [4:0] wreg,
                           input logic wen, input logic [31:0] alu, input logic [31:0] rf,
                           input logic [31:0] pc);
    bus.in_valid = 1; bus.in_op = op; bus.in_off = off; bus.in_wreg = wreg;
    bus.in_wen = wen; bus.in_alu = alu; bus.in_rf = rf; bus.in_pc = pc;
    @(negedge clk);
    bus.in_valid = 0;
    #1;
  endtask

  task automatic drive_resp(input logic [31:0] d);
    bus.dc_data_ok = 1; bus.dc_rdata = d;
    @(negedge clk);
    bus.dc_data_ok = 0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.fwd_busy !== 1'b0) begin n_bad++; $display("FAIL reset_fwd_busy: got %b want 0", bus.fwd_busy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.spurious !== 1'b0) begin n_bad++; $display("FAIL reset_spurious: got %b want 0", bus.spurious); end
    // Reset while loads are outstanding.
    drive_enq(3'd5, 2'd0, 5'd1, 1'b1, 32'h0, 32'h0, 32'h40);
    drive_enq(3'd5, 2'd0, 5'd2, 1'b1, 32'h0, 32'h0, 32'h44);
    do_reset();
    n_cmp++; if (bus.count !== '0) begin n_bad++; $display("FAIL midreset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.fwd_busy !== 1'b0) begin n_bad++; $display("FAIL midreset_fwd_busy: got %b want 0", bus.fwd_busy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_passthrough();
    bus.out_ready = 1;
    drive_enq(3'd0, 2'd0, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h100);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL pass_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_wdata !== 32'h1234) begin n_bad++; $display("FAIL pass_wdata: got %h want 00001234", bus.out_wdata); end
    n_cmp++; if (bus.out_wmask !== 4'b1111) begin n_bad++; $display("FAIL pass_wmask: got %b want 1111", bus.out_wmask); end
    n_cmp++; if (bus.out_wreg !== 5'd5) begin n_bad++; $display("FAIL pass_wreg: got %0d want 5", bus.out_wreg); end
    n_cmp++; if (bus.out_pc !== 32'h100) begin n_bad++; $display("FAIL pass_pc: got %h want 00000100", bus.out_pc); end
    @(negedge clk); #1;
    bus.out_ready = 0;
    n_cmp++; if (bus.count !== '0) begin n_bad++; $display("FAIL pass_drain: got %0d want 0", bus.count); end
  endtask

  task automatic test_byte_half();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hFFFFFF80; exp_d[1] = 32'h00000080; exp_d[2] = 32'hFFFF80FF;
    drive_enq(3'd1, 2'd3, 5'd1, 1'b1, 32'h0, 32'h0, 32'h200);
    drive_enq(3'd2, 2'd3, 5'd2, 1'b1, 32'h0, 32'h0, 32'h204);
    drive_enq(3'd3, 2'd2, 5'd3, 1'b1, 32'h0, 32'h0, 32'h208);
    n_cmp++; if (bus.count !== CNT_W'(3)) begin n_bad++; $display("FAIL bh_count: got %0d want 3", bus.count); end
    n_cmp++; if (bus.fwd_busy !== 1'b1) begin n_bad++; $display("FAIL bh_busy: got %b want 1", bus.fwd_busy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bh_early_valid: got %b want 0", bus.out_valid); end
    repeat (3) drive_resp(32'h80FF7F01);
    n_cmp++; if (bus.fwd_busy !== 1'b0) begin n_bad++; $display("FAIL bh_busy_clear: got %b want 0", bus.fwd_busy); end
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bh_valid%0d: got %b want 1", i, bus.out_valid); end
      n_cmp++; if (bus.out_wdata !== exp_d[i]) begin n_bad++; $display("FAIL bh_wdata%0d: got %h want %h", i, bus.out_wdata, exp_d[i]); end
      n_cmp++; if (bus.out_wreg !== 5'(i + 1)) begin n_bad++; $display("FAIL bh_wreg%0d: got %0d want %0d", i, bus.out_wreg, i + 1); end
      @(negedge clk); #1;
    end
    bus.out_ready = 0;
    n_cmp++; if (bus.count !== '0) begin n_bad++; $display("FAIL bh_drain: got %0d want 0", bus.count); end
  endtask

  task automatic test_lwl_lwr();
    drive_enq(3'd6, 2'd1, 5'd7, 1'b1, 32'h0, 32'hAABBCCDD, 32'h300);
    drive_enq(3'd7, 2'd2, 5'd8, 1'b1, 32'h0, 32'hAABBCCDD, 32'h304);
    repeat (2) drive_resp(32'h11223344);
    n_cmp++; if (bus.out_wdata !== 32'h3344CCDD) begin n_bad++; $display("FAIL lwl_wdata: got %h want 3344ccdd", bus.out_wdata); end
    n_cmp++; if (bus.out_wmask !== 4'b1100) begin n_bad++; $display("FAIL lwl_wmask: got %b want 1100", bus.out_wmask); end
    bus.out_ready = 1;
    @(negedge clk); #1;
    n_cmp++; if (bus.out_wdata !== 32'h00001122) begin n_bad++; $display("FAIL lwr_wdata: got %h want 00001122", bus.out_wdata); end
    n_cmp++; if (bus.out_wmask !== 4'b0011) begin n_bad++; $display("FAIL lwr_wmask: got %b want 0011", bus.out_wmask); end
    @(negedge clk); #1;
    bus.out_ready = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) drive_enq(3'd5, 2'd0, 5'(10 + i), 1'b1, 32'h0, 32'h0, 32'(32'h400 + 4 * i));
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.count !== CNT_W'(DEPTH)) begin n_bad++; $display("FAIL full_count: got %0d want %0d", bus.count, DEPTH); end
    bus.out_ready = 1;
    drive_resp(32'hCAFEF00D);
    n_cmp++; if (bus.out_wdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL full_head_data: got %h want cafef00d", bus.out_wdata); end
    @(negedge clk); #1;
    bus.out_ready = 0;
    n_cmp++; if (bus.count !== CNT_W'(DEPTH - 1)) begin n_bad++; $display("FAIL full_retire_count: got %0d want %0d", bus.count, DEPTH - 1); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL full_retire_ready: got %b want 1", bus.in_ready); end
  endtask

  // Picks up the three loads still pending from test_fill.
  task automatic test_flush_drop();
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    #1;
    n_cmp++; if (bus.count !== '0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      drive_resp($urandom);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL drop_valid%0d: got %b want 0", i, bus.out_valid); end
      n_cmp++; if (bus.in_ready !== (i == 2)) begin n_bad++; $display("FAIL drop_ready%0d: got %b want %b", i, bus.in_ready, i == 2); end
    end
    n_cmp++; if (bus.spurious !== 1'b0) begin n_bad++; $display("FAIL drop_spurious: got %b want 0", bus.spurious); end
  endtask

  task automatic test_spurious();
    drive_resp(32'h5A5A5A5A);
    n_cmp++; if (bus.spurious !== 1'b1) begin n_bad++; $display("FAIL spur_set: got %b want 1", bus.spurious); end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.spurious !== 1'b1) begin n_bad++; $display("FAIL spur_sticky: got %b want 1", bus.spurious); end
    do_reset();
    n_cmp++; if (bus.spurious !== 1'b0) begin n_bad++; $display("FAIL spur_reset: got %b want 0", bus.spurious); end
  endtask

  task automatic test_random(input int cycles);
    ent_t e;
    int pend, j;
    bit exp_rdy, exp_vld, exp_byp, pop;
    logic [35:0] byp_v;
    do_reset();
    mq.delete(); mdrop = 0; mspur = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      pend = 0; j = -1;
      foreach (mq[i]) if (!mq[i].done) begin pend++; if (j < 0) j = i; end
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_op     = 3'($urandom_range(0, 7));
      bus.in_off    = 2'($urandom_range(0, 3));
      bus.in_wreg   = 5'($urandom_range(0, 31));
      bus.in_wen    = 1'($urandom_range(0, 1));
      bus.in_alu    = $urandom; bus.in_rf = $urandom; bus.in_pc = $urandom;
      bus.flush     = ($urandom_range(0, 31) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.dc_rdata  = $urandom;
      bus.dc_data_ok = ((mdrop + pend) > 0) && ($urandom_range(0, 9) < 4) && !(bus.flush && mdrop == 0);
      #1;
      exp_rdy = (mq.size() < DEPTH) && (mdrop == 0);
      exp_byp = 0;
`ifdef MEM_RESP_BYPASS_EN
      exp_byp = bus.dc_data_ok && (mdrop == 0) && (j == 0) && !bus.flush;
`endif
      exp_vld = ((mq.size() > 0) && mq[0].done) || exp_byp;
      n_cmp++; if (bus.in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, bus.in_ready, exp_rdy); end
      n_cmp++; if (bus.out_valid !== exp_vld) begin n_bad++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, bus.out_valid, exp_vld); end
      n_cmp++; if (bus.count !== CNT_W'(mq.size())) begin n_bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus.count, mq.size()); end
      n_cmp++; if (bus.fwd_busy !== (pend > 0)) begin n_bad++; $display("FAIL rnd_fwd_busy c%0d: got %b want %b", c, bus.fwd_busy, pend > 0); end
      n_cmp++; if (bus.spurious !== mspur) begin n_bad++; $display("FAIL rnd_spurious c%0d: got %b want %b", c, bus.spurious, mspur); end
      if (exp_vld) begin
        e = mq[0];
        if (exp_byp) begin
          byp_v = ref_load(int'(e.op), int'(e.off), bus.dc_rdata, e.rf, e.wen);
          e.mask = byp_v[35:32]; e.data = byp_v[31:0];
        end
        n_cmp++; if (bus.out_pc !== e.pc) begin n_bad++; $display("FAIL rnd_pc c%0d: got %h want %h", c, bus.out_pc, e.pc); end
        n_cmp++; if (bus.out_wreg !== e.wreg) begin n_bad++; $display("FAIL rnd_wreg c%0d: got %0d want %0d", c, bus.out_wreg, e.wreg); end
        n_cmp++; if (bus.out_wdata !== e.data) begin n_bad++; $display("FAIL rnd_wdata c%0d op%0d off%0d: got %h want %h", c, e.op, e.off, bus.out_wdata, e.data); end
        n_cmp++; if (bus.out_wmask !== e.mask) begin n_bad++; $display("FAIL rnd_wmask c%0d op%0d off%0d: got %b want %b", c, e.op, e.off, bus.out_wmask, e.mask); end
      end
      pop = exp_vld && bus.out_ready;
      if (bus.dc_data_ok) begin
        if (mdrop > 0) mdrop--;
        else if (pend > 0) begin
          if (!bus.flush) begin
            e = mq[j];
            {e.mask, e.data} = ref_load(int'(e.op), int'(e.off), bus.dc_rdata, e.rf, e.wen);
            e.done = 1;
            mq[j] = e;
          end
        end else mspur = 1;
      end
      if (pop) void'(mq.pop_front());
      if (bus.flush) begin
        foreach (mq[i]) if (!mq[i].done) mdrop++;
        mq.delete();
      end else if (bus.in_valid && exp_rdy) begin
        e.op = bus.in_op; e.off = bus.in_off; e.wreg = bus.in_wreg; e.wen = bus.in_wen;
        e.rf = bus.in_rf; e.pc = bus.in_pc; e.data = bus.in_alu;
        e.mask = bus.in_wen ? 4'hF : 4'h0; e.done = (bus.in_op == 3'd0);
        mq.push_back(e);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_passthrough();
    test_byte_half();
    test_lwl_lwr();
    test_fill();
    test_flush_drop();
    test_spurious();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
